// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: round-robin RED/GREEN/YELLOW sequencer for NUM_DIR signal heads,
// with all-red clearance between directions and tick-strobed phase timers.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   tick            timer advance strobe (one clk wide)
//   hold            freezes phase, direction and timer while high
//   ped_req         pedestrian request (level or pulse)
//   light           3 bits per head, head d at [3d+2:3d]: RED=100 YELLOW=010 GREEN=001
//   dir_idx         index of the active direction
//   phase           00 ALL_RED, 01 GREEN, 10 YELLOW, 11 PED
//   walk            pedestrian walk indication
//   ped_pending     pedestrian request latched and not yet served
// Build option: define TL_PED_REQ_EN to compile in the pedestrian phase.
module traffic_light_ctrl #(
    parameter int NUM_DIR    = 2,
    parameter int CNT_W      = 16,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 1,
    parameter int PED_CYC    = 4,
    localparam int DW = (NUM_DIR > 2) ? $clog2(NUM_DIR) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 hold,
    input  logic                 ped_req,
    output logic [3*NUM_DIR-1:0] light,
    output logic [DW-1:0]        dir_idx,
    output logic [1:0]           phase,
    output logic                 walk,
    output logic                 ped_pending
);
    typedef enum logic [1:0] {
        ALL_RED = 2'b00,
        GREEN   = 2'b01,
        YELLOW  = 2'b10,
        PED     = 2'b11
    } phase_t;

    localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] T_GREEN  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW_CYC - 1);
    localparam logic [DW-1:0]    LAST_DIR = DW'(NUM_DIR - 1);

    phase_t           phase_q, phase_d;
    logic [DW-1:0]    dir_q, dir_d, dir_inc;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             adv, done;

`ifdef TL_PED_REQ_EN
    localparam logic [CNT_W-1:0] T_PED = CNT_W'(PED_CYC - 1);
    logic ped_q, ped_go;
`endif

    assign adv     = tick && !hold;
    assign done    = adv && (timer_q == '0);
    assign dir_inc = (dir_q == LAST_DIR) ? '0 : dir_q + 1'b1;

    always_comb begin
        phase_d = phase_q;
        dir_d   = dir_q;
        timer_d = (adv && timer_q != '0) ? timer_q - 1'b1 : timer_q;
        case (phase_q)
            ALL_RED: if (done) begin
                phase_d = GREEN;
                timer_d = T_GREEN;
            end
            GREEN: if (done) begin
                phase_d = YELLOW;
                timer_d = T_YELLOW;
            end
`ifdef TL_PED_REQ_EN
            YELLOW: if (done && ped_q) begin
                phase_d = PED;
                timer_d = T_PED;
            end else if (done) begin
                phase_d = ALL_RED;
                dir_d   = dir_inc;
                timer_d = T_ALLRED;
            end
            PED: if (done) begin
                phase_d = ALL_RED;
                dir_d   = dir_inc;
                timer_d = T_ALLRED;
            end
`else
            YELLOW: if (done) begin
                phase_d = ALL_RED;
                dir_d   = dir_inc;
                timer_d = T_ALLRED;
            end
`endif
            // unreachable encodings fall back to clearance on the same direction
            default: begin
                phase_d = ALL_RED;
                timer_d = T_ALLRED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= ALL_RED;
            dir_q   <= '0;
            timer_q <= T_ALLRED;
        end else begin
            phase_q <= phase_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
        end
    end

`ifdef TL_PED_REQ_EN
    // a request arriving in the very cycle PED is entered counts as served
    assign ped_go = (phase_q == YELLOW) && done && ped_q;

    always_ff @(posedge clk) begin
        if (reset || ped_go)
            ped_q <= 1'b0;
        else if (ped_req && phase_q != PED)
            ped_q <= 1'b1;
    end

    assign walk        = (phase_q == PED);
    assign ped_pending = ped_q;
`else
    logic unused_ped;
    assign unused_ped  = ped_req ^ (PED_CYC > 0);
    assign walk        = 1'b0;
    assign ped_pending = 1'b0;
`endif

    for (genvar d = 0; d < NUM_DIR; d++) begin : g_head
        localparam logic [DW-1:0] IDX = DW'(d);
        assign light[3*d +: 3] = (dir_q != IDX)      ? 3'b100 :
                                 (phase_q == GREEN)  ? 3'b001 :
                                 (phase_q == YELLOW) ? 3'b010 : 3'b100;
    end

    assign phase   = phase_q;
    assign dir_idx = dir_q;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: table-driven, scenario and randomized checks of traffic_light_ctrl
module tb_traffic_light_ctrl;
    localparam int ND = 3;
    localparam int GC = 4;
    localparam int YC = 2;
    localparam int AC = 1;
    localparam int PC = 3;
`ifdef TL_PED_REQ_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif
    localparam logic [8:0] ALLR = 9'b100_100_100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       hold = 1'b0;
    logic       ped_req = 1'b0;
    logic [8:0] light;
    logic [1:0] dir_idx;
    logic [1:0] phase;
    logic       walk;
    logic       ped_pending;

    int checks = 0;
    int errors = 0;

    // reference state: phase code, direction, ticks consumed in phase, pending request
    int m_ph, m_dir, m_el;
    bit m_pend;
    int dur[4];

    typedef struct {
        bit         r, t, h, p;
        logic [8:0] light;
        int         dir, ph;
    } vec_t;
    vec_t tbl[$];

    traffic_light_ctrl #(
        .NUM_DIR(ND), .CNT_W(16), .GREEN_CYC(GC), .YELLOW_CYC(YC),
        .ALLRED_CYC(AC), .PED_CYC(PC)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .hold(hold), .ped_req(ped_req),
        .light(light), .dir_idx(dir_idx), .phase(phase), .walk(walk),
        .ped_pending(ped_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [8:0] exp_light();
        logic [8:0] l;
        l = ALLR;
        if (m_ph == 1) l[3*m_dir +: 3] = 3'b001;
        else if (m_ph == 2) l[3*m_dir +: 3] = 3'b010;
        return l;
    endfunction

    task automatic model_update(input bit r, input bit t, input bit h, input bit p);
        int old;
        bit served;
        old = m_ph;
        served = 1'b0;
        if (r) begin
            m_ph = 0; m_dir = 0; m_el = 0; m_pend = 1'b0;
            return;
        end
        if (t && !h) begin
            m_el++;
            if (m_el == dur[m_ph]) begin
                m_el = 0;
                if (m_ph == 2 && m_pend) begin
                    m_ph = 3;
                    served = 1'b1;
                end else if (m_ph >= 2) begin
                    m_ph = 0;
                    m_dir = (m_dir + 1) % ND;
                end else begin
                    m_ph++;
                end
            end
        end
        if (PED_EN) m_pend = served ? 1'b0 : (p && old != 3) ? 1'b1 : m_pend;
    endtask

    task automatic check_model();
        chk("light", int'(light), int'(exp_light()));
        chk("dir_idx", int'(dir_idx), m_dir);
        chk("phase", int'(phase), m_ph);
        chk("walk", int'(walk), int'(m_ph == 3));
        chk("ped_pending", int'(ped_pending), int'(m_pend));
    endtask

    task automatic step(input bit r, input bit t, input bit h, input bit p);
        reset = r; tick = t; hold = h; ped_req = p;
        @(posedge clk);
        model_update(r, t, h, p);
        @(negedge clk);
        check_model();
    endtask

    task automatic add(input bit r, input bit t, input bit h, input bit p,
                       input logic [8:0] l, input int d, input int ph, input int n);
        vec_t v;
        v.r = r; v.t = t; v.h = h; v.p = p; v.light = l; v.dir = d; v.ph = ph;
        repeat (n) tbl.push_back(v);
    endtask

    initial begin
        int g, y, n;
        dur = '{AC, GC, YC, PC};

        // basic cycle with tick held high: one expected row per clock edge
        add(1, 0, 0, 0, ALLR,           0, 0, 1);
        add(0, 1, 0, 0, 9'b100_100_001, 0, 1, 4);
        add(0, 1, 0, 0, 9'b100_100_010, 0, 2, 2);
        add(0, 1, 0, 0, ALLR,           1, 0, 1);
        add(0, 1, 0, 0, 9'b100_001_100, 1, 1, 4);
        add(0, 1, 0, 0, 9'b100_010_100, 1, 2, 2);
        add(0, 1, 0, 0, ALLR,           2, 0, 1);
        add(0, 1, 0, 0, 9'b001_100_100, 2, 1, 4);
        add(0, 1, 0, 0, 9'b010_100_100, 2, 2, 2);
        add(0, 1, 0, 0, ALLR,           0, 0, 1);
        add(0, 1, 0, 0, 9'b100_100_001, 0, 1, 1);
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].t, tbl[i].h, tbl[i].p);
            chk("tbl_light", int'(light), int'(tbl[i].light));
            chk("tbl_dir", int'(dir_idx), tbl[i].dir);
            chk("tbl_phase", int'(phase), tbl[i].ph);
        end

        // tick every third clock stretches each phase threefold
        step(1, 0, 0, 0);
        g = 0; y = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, (i % 3) == 2, 0, 0);
            if (dir_idx == 0 && phase == 2'b01) g++;
            if (dir_idx == 0 && phase == 2'b10) y++;
        end
        chk("gate_green_len", g, 12);
        chk("gate_yellow_len", y, 6);

        // hold for five cycles in dir0 GREEN
        step(1, 0, 0, 0);
        g = 0;
        for (int i = 1; i <= 12; i++) begin
            step(0, 1, (i >= 3 && i <= 7), 0);
            if (i >= 3 && i <= 7) begin
                chk("hold_phase", int'(phase), 1);
                chk("hold_dir", int'(dir_idx), 0);
            end
            if (dir_idx == 0 && phase == 2'b01) g++;
        end
        chk("hold_green_len", g, 9);

`ifdef TL_PED_REQ_EN
        // pedestrian request pulsed during dir1 GREEN
        step(1, 0, 0, 0);
        repeat (8) step(0, 1, 0, 0);
        chk("ped_pre_phase", int'(phase), 1);
        chk("ped_pre_dir", int'(dir_idx), 1);
        step(0, 1, 0, 1);
        chk("ped_pending_set", int'(ped_pending), 1);
        for (int i = 0; i < 30 && phase != 2'b11; i++) step(0, 1, 0, 0);
        chk("ped_entered", int'(phase), 3);
        chk("ped_entry_dir", int'(dir_idx), 1);
        n = 0;
        for (int i = 0; i < 10 && phase == 2'b11; i++) begin
            n++;
            chk("ped_walk", int'(walk), 1);
            chk("ped_light", int'(light), int'(ALLR));
            chk("ped_pending_clr", int'(ped_pending), 0);
            step(0, 1, 0, 0);
        end
        chk("ped_len", n, 3);
        chk("ped_after_phase", int'(phase), 0);
        chk("ped_after_dir", int'(dir_idx), 2);

        // request held through the PED phase is never latched
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        repeat (4) step(0, 1, 0, 0);
        chk("rdp_pend_before", int'(ped_pending), 1);
        step(0, 1, 0, 1);
        chk("rdp_entry_phase", int'(phase), 3);
        chk("rdp_entry_pend", int'(ped_pending), 0);
        step(0, 1, 0, 1);
        chk("rdp_mid_pend", int'(ped_pending), 0);
        step(0, 1, 0, 1);
        chk("rdp_last_pend", int'(ped_pending), 0);
        step(0, 1, 0, 0);
        chk("rdp_exit_phase", int'(phase), 0);
        chk("rdp_exit_dir", int'(dir_idx), 1);
        chk("rdp_exit_pend", int'(ped_pending), 0);
        n = 0;
        repeat (25) begin
            step(0, 1, 0, 0);
            if (phase == 2'b11) n++;
        end
        chk("rdp_no_second_ped", n, 0);
`endif

        // reset during dir2 YELLOW with a request pending
        step(1, 0, 0, 0);
        repeat (15) step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        repeat (3) step(0, 1, 0, 0);
        chk("rst_pre_phase", int'(phase), 2);
        chk("rst_pre_dir", int'(dir_idx), 2);
        chk("rst_pre_pend", int'(ped_pending), int'(PED_EN));
        step(1, 1, 0, 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_dir", int'(dir_idx), 0);
        chk("rst_light", int'(light), int'(ALLR));
        chk("rst_pend", int'(ped_pending), 0);
        chk("rst_walk", int'(walk), 0);
        step(0, 1, 0, 0);
        chk("rst_restart_light", int'(light), int'(9'b100_100_001));
        chk("rst_restart_phase", int'(phase), 1);

        // randomized traffic against the reference model
        step(1, 0, 0, 0);
        repeat (3000)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
